// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that gives NREQ requesters shared write access to one WIDTH-bit register.
// After each commit it holds off further writes for GAP cool-down cycles.
module reg_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     wdata,
   output logic [NREQ-1:0]           ack,
   output logic [WIDTH-1:0]          q,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   last_id
);

   localparam int IDW     = $clog2(NREQ);
   localparam int GAP_EFF = (GAP < 1) ? 1 : ((GAP > 7) ? 7 : GAP);

   typedef enum logic {IDLE, COOL} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [2:0]       cnt;
   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW:0]     pos;
   logic [WIDTH-1:0] win_data;

   // Rotating priority search: first set req at or above ptr, wrapping at NREQ.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      found    = 1'b0;
      win      = '0;
      pos      = '0;
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, ptr} + (IDW+1)'(k);
         if (pos >= (IDW+1)'(NREQ))
            pos = pos - (IDW+1)'(NREQ);
         if (!found && req[pos[IDW-1:0]]) begin
            found = 1'b1;
            win   = pos[IDW-1:0];
         end
      end
      for (int k = 0; k < NREQ; k++)
         if (win == IDW'(k))
            win_data = wdata[k*WIDTH +: WIDTH];
   end

   // NOTE: all state here uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         ack     <= '0;
         q       <= '0;
         busy    <= 1'b0;
         last_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (found) begin
                  q       <= win_data;
                  ack     <= NREQ'(1) << win;
                  last_id <= win;
                  ptr     <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
                  cnt     <= 3'(GAP_EFF);
                  busy    <= 1'b1;
                  state   <= COOL;
               end
            end
            COOL: begin
               ack <= '0;
               // Leaving on the last count lets the following IDLE cycle arbitrate at once.
               if (cnt <= 3'd1) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: GAP=1 and GAP=3 instances, scoreboard of expected commits.
module tb_reg_write_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req1, req3, ack1, ack3;
   logic [NREQ*WIDTH-1:0] wdata1, wdata3;
   logic [WIDTH-1:0]      q1, q3;
   logic                  busy1, busy3;
   logic [IDW-1:0]        lid1, lid3;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .wdata(wdata1),
      .ack(ack1), .q(q1), .busy(busy1), .last_id(lid1)
   );

   reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .wdata(wdata3),
      .ack(ack3), .q(q3), .busy(busy3), .last_id(lid3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Waits (at negedges) for an ack from the selected instance and scores it against the queue head.
   task automatic wait_ack(input int which, input int budget, input bit drop, output int cycles);
      logic [NREQ-1:0] a;
      exp_t            e;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         a = (which == 1) ? ack1 : ack3;
      end while (a == '0 && cycles < budget);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed ack %0h expected no pending entry", a);
         return;
      end
      e = exp_q.pop_front();
      if (which == 1) begin
         check("ack1", 32'(ack1), 32'(1) << e.id);
         check("q1", 32'(q1), 32'(e.data));
         check("last_id1", 32'(lid1), 32'(e.id));
         check("busy1_ack", 32'(busy1), 32'd1);
         if (drop) req1 = req1 & ~ack1;
      end else begin
         check("ack3", 32'(ack3), 32'(1) << e.id);
         check("q3", 32'(q3), 32'(e.data));
         check("last_id3", 32'(lid3), 32'(e.id));
         check("busy3_ack", 32'(busy3), 32'd1);
         if (drop) req3 = req3 & ~ack3;
      end
   endtask

   initial begin
      int cyc;
      logic [NREQ*WIDTH-1:0] rr_data;
      rr_data = {4'b0011, 4'b1111, 4'b1010, 4'b0000};

      // Reset held two cycles with every request up.
      rst    = 1'b1;
      req1   = 4'b1111;
      req3   = 4'b0000;
      wdata1 = rr_data;
      wdata3 = '0;
      repeat (2) begin
         @(negedge clk);
         check("rst_q", 32'(q1), 32'd0);
         check("rst_ack", 32'(ack1), 32'd0);
         check("rst_busy", 32'(busy1), 32'd0);
         check("rst_last_id", 32'(lid1), 32'd0);
      end

      // Round robin 0,1,2,3 straight out of reset, one commit every GAP+1 cycles.
      for (int i = 0; i < NREQ; i++)
         exp_q.push_back('{id: i, data: rr_data[i*WIDTH +: WIDTH]});
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         wait_ack(1, 6, 1'b1, cyc);
         check("rr_spacing", 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
      end

      // Wrap: after winner 3 the pointer is 0, so 0 then 3.
      req1 = 4'b1001;
      exp_q.push_back('{id: 0, data: 4'b0000});
      exp_q.push_back('{id: 3, data: 4'b0011});
      wait_ack(1, 6, 1'b1, cyc);
      check("wrap_spacing0", 32'(cyc), 32'd2);
      wait_ack(1, 6, 1'b1, cyc);
      check("wrap_spacing3", 32'(cyc), 32'd2);

      // Single requester; req stays up through the ack cycle and must not be re-granted.
      @(negedge clk);
      check("idle_busy", 32'(busy1), 32'd0);
      wdata1         = {$urandom, $urandom} & {NREQ*WIDTH{1'b1}};
      wdata1[11:8]   = 4'b1010;
      req1           = 4'b0100;
      exp_q.push_back('{id: 2, data: 4'b1010});
      wait_ack(1, 6, 1'b0, cyc);
      check("single_latency", 32'(cyc), 32'd1);
      @(negedge clk);
      check("single_ack_pulse", 32'(ack1), 32'd0);
      check("single_busy_drop", 32'(busy1), 32'd0);
      req1 = 4'b0000;
      repeat (3) begin
         @(negedge clk);
         check("no_second_ack", 32'(ack1), 32'd0);
         check("q_hold", 32'(q1), 32'(4'b1010));
      end

      // GAP=3: two requesters, commits exactly 4 cycles apart, busy for 3.
      wdata3 = {4'b0000, 4'b0000, 4'b0110, 4'b1001};
      req3   = 4'b0011;
      exp_q.push_back('{id: 0, data: 4'b1001});
      wait_ack(3, 6, 1'b1, cyc);
      check("gap3_latency", 32'(cyc), 32'd1);
      exp_q.push_back('{id: 1, data: 4'b0110});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("gap3_busy", 32'(busy3), (k < 2) ? 32'd1 : 32'd0);
         check("gap3_ack_low", 32'(ack3), 32'd0);
         check("gap3_q_hold", 32'(q3), 32'(4'b1001));
      end
      wait_ack(3, 6, 1'b1, cyc);
      check("gap3_spacing", 32'(cyc), 32'd1);

      // Reset in the ack cycle of a commit by requester 2 (pointer would otherwise be 3).
      repeat (4) @(negedge clk);
      wdata1 = {4'b1100, 4'b0111, 4'b0101, 4'b0001};
      req1   = 4'b0100;
      exp_q.push_back('{id: 2, data: 4'b0111});
      wait_ack(1, 6, 1'b1, cyc);
      rst  = 1'b1;
      req1 = 4'b1010;
      @(negedge clk);
      check("midrst_ack", 32'(ack1), 32'd0);
      check("midrst_q", 32'(q1), 32'd0);
      check("midrst_busy", 32'(busy1), 32'd0);
      check("midrst_last_id", 32'(lid1), 32'd0);
      check("midrst_q3", 32'(q3), 32'd0);
      rst = 1'b0;
      exp_q.push_back('{id: 1, data: 4'b0101});
      exp_q.push_back('{id: 3, data: 4'b1100});
      wait_ack(1, 6, 1'b1, cyc);
      check("midrst_first_grant", 32'(cyc), 32'd1);
      wait_ack(1, 6, 1'b1, cyc);
      check("midrst_second_grant", 32'(cyc), 32'd2);
      req1 = 4'b0000;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
